// File: rtl/half_adder.sv
// Multi-lane half adder with carry statistics (sticky flag, saturating count).
// Define HALF_ADDER_COMB_EN for combinational sum/carry/carry_any/out_valid.
module half_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             clr,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic             out_valid,
    output logic             carry_any,
    output logic             carry_sticky,
    output logic [CNT_W-1:0] carry_cnt
);

    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] carry_c;
    logic             any_c;
    logic             cnt_full;

    assign sum_c    = a ^ b;
    assign carry_c  = a & b;
    assign any_c    = |carry_c;
    assign cnt_full = &carry_cnt;

    // clr takes priority over a carry-producing op on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_sticky <= 1'b0;
            carry_cnt    <= '0;
        end else if (clr) begin
            carry_sticky <= 1'b0;
            carry_cnt    <= '0;
        end else if (in_valid && any_c) begin
            carry_sticky <= 1'b1;
            if (!cnt_full) begin
                carry_cnt <= carry_cnt + CNT_W'(1);
            end
        end
    end

`ifdef HALF_ADDER_COMB_EN
    assign sum       = sum_c;
    assign carry     = carry_c;
    assign carry_any = any_c;
    assign out_valid = in_valid;
`else
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;
    logic             any_q;
    logic             valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= '0;
            any_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sum_q   <= sum_c;
                carry_q <= carry_c;
                any_q   <= any_c;
            end
        end
    end

    assign sum       = sum_q;
    assign carry     = carry_q;
    assign carry_any = any_q;
    assign out_valid = valid_q;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Directed self-checking bench for half_adder: an 8-lane instance and a
// 1-lane instance with a 2-bit counter to reach saturation quickly.
module tb_half_adder;

    logic       clk;
    logic       rst_n;

    logic [7:0] a8, b8;
    logic       v8, c8;
    logic [7:0] sum8, carry8;
    logic       ov8, any8, st8;
    logic [15:0] cnt8;

    logic       a1, b1;
    logic       v1, c1;
    logic       sum1, carry1;
    logic       ov1, any1, st1;
    logic [1:0] cnt1;

    int total;
    int bad;

    half_adder #(.WIDTH(8), .CNT_W(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8),
        .in_valid(v8), .clr(c8), .sum(sum8), .carry(carry8),
        .out_valid(ov8), .carry_any(any8),
        .carry_sticky(st8), .carry_cnt(cnt8)
    );

    half_adder #(.WIDTH(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1),
        .in_valid(v1), .clr(c1), .sum(sum1), .carry(carry1),
        .out_valid(ov1), .carry_any(any1),
        .carry_sticky(st1), .carry_cnt(cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        a8 = 8'h00; b8 = 8'h00; v8 = 1'b0; c8 = 1'b0;
        a1 = 1'b0;  b1 = 1'b0;  v1 = 1'b0; c1 = 1'b0;
        #12;
`ifndef HALF_ADDER_COMB_EN
        chk("rst_sum8", sum8, 0);
        chk("rst_carry8", carry8, 0);
        chk("rst_any8", any8, 0);
        chk("rst_ov8", ov8, 0);
`endif
        chk("rst_cnt8", cnt8, 0);
        chk("rst_st8", st8, 0);
        chk("rst_cnt1", cnt1, 0);
        chk("rst_st1", st1, 0);
        rst_n = 1'b1;
        tick();

        // truth table on the single-lane instance
        v1 = 1'b1; a1 = 1'b0; b1 = 1'b0; tick();
        chk("tt00_sum", sum1, 0);
        chk("tt00_carry", carry1, 0);
        chk("tt00_ov", ov1, 1);
        a1 = 1'b0; b1 = 1'b1; tick();
        chk("tt01_sum", sum1, 1);
        chk("tt01_carry", carry1, 0);
        chk("tt01_ov", ov1, 1);
        a1 = 1'b1; b1 = 1'b0; tick();
        chk("tt10_sum", sum1, 1);
        chk("tt10_carry", carry1, 0);
        a1 = 1'b1; b1 = 1'b1; tick();
        chk("tt11_sum", sum1, 0);
        chk("tt11_carry", carry1, 1);
        chk("tt11_any", any1, 1);
        chk("tt11_cnt", cnt1, 1);
        chk("tt11_st", st1, 1);

        // idle cycle: no count, out_valid drops, outputs hold
        v1 = 1'b0; tick();
        chk("idle_ov1", ov1, 0);
        chk("idle_carry1", carry1, 1);
        chk("idle_cnt1", cnt1, 1);

        // counter saturation at 2'b11
        v1 = 1'b1; tick();
        chk("sat_pre", cnt1, 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sat_hold", cnt1, 3);
        end

        // clr wins over a carry op on the same edge
        c1 = 1'b1; tick();
        chk("clr1_cnt", cnt1, 0);
        chk("clr1_st", st1, 0);
        chk("clr1_carry", carry1, 1);
        c1 = 1'b0; v1 = 1'b0;

        // 8-lane pattern
        v8 = 1'b1; a8 = 8'hF0; b8 = 8'h3C; tick();
        chk("w8_sum", sum8, 8'hCC);
        chk("w8_carry", carry8, 8'h30);
        chk("w8_any", any8, 1);
        chk("w8_cnt", cnt8, 1);
        chk("w8_st", st8, 1);
        chk("w8_ov", ov8, 1);
        a8 = 8'h0F; b8 = 8'hF0; tick();
        chk("w8b_sum", sum8, 8'hFF);
        chk("w8b_carry", carry8, 8'h00);
        chk("w8b_any", any8, 0);
        chk("w8b_cnt", cnt8, 1);
        chk("w8b_st", st8, 1);

        v8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; tick();
`ifndef HALF_ADDER_COMB_EN
        chk("hold8_sum", sum8, 8'hFF);
        chk("hold8_carry", carry8, 8'h00);
`endif
        chk("hold8_ov", ov8, 0);
        chk("hold8_cnt", cnt8, 1);

        v8 = 1'b1; c8 = 1'b1; tick();
        chk("clr8_cnt", cnt8, 0);
        chk("clr8_st", st8, 0);
        chk("clr8_carry", carry8, 8'hFF);
        chk("clr8_sum", sum8, 8'h00);
        c8 = 1'b0;

        // async reset mid-cycle
        a8 = 8'h03; b8 = 8'h02; tick();
        chk("pre_rst_sum", sum8, 8'h01);
        chk("pre_rst_cnt", cnt8, 1);
        #2 rst_n = 1'b0;
        #1;
`ifndef HALF_ADDER_COMB_EN
        chk("arst_sum", sum8, 0);
        chk("arst_carry", carry8, 0);
        chk("arst_any", any8, 0);
        chk("arst_ov", ov8, 0);
`endif
        chk("arst_cnt", cnt8, 0);
        chk("arst_st", st8, 0);
        tick();
`ifndef HALF_ADDER_COMB_EN
        chk("inrst_ov", ov8, 0);
`endif
        chk("inrst_cnt", cnt8, 0);
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_ov", ov8, 1);
        chk("post_rst_sum", sum8, 8'h01);
        chk("post_rst_cnt", cnt8, 1);

`ifdef HALF_ADDER_COMB_EN
        #2;
        a1 = 1'b1; b1 = 1'b1; v1 = 1'b0;
        #1;
        chk("comb_sum", sum1, 0);
        chk("comb_carry", carry1, 1);
        chk("comb_ov", ov1, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
